// File: rtl/dma_write_desc_queue.sv
`timescale 1ns/1ps
// Write-descriptor front-end: descriptor FIFO, one-at-a-time command issue, per-descriptor status return.
// Optional build macro DESC_FLUSH_ON_ERR_EN: after an ABORT record, drain the queue with FLUSHED records.
module dma_write_desc_queue #(
    parameter int AXI_ID_WD   = 2,
    parameter int AXI_ADDR_WD = 32,
    parameter int DESC_DEPTH  = 4
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESET,
    input  logic                          desc_valid,
    output logic                          desc_ready,
    input  logic [AXI_ADDR_WD-1:0]        desc_addr,
    input  logic [AXI_ADDR_WD-1:0]        desc_len,
    input  logic [AXI_ID_WD-1:0]          desc_id,
    input  logic [1:0]                    desc_burst,
    input  logic [2:0]                    desc_size,
    output logic                          w_cmd_valid,
    input  logic                          w_cmd_ready,
    input  logic                          w_cmd_abort,
    output logic [AXI_ADDR_WD-1:0]        w_cmd_addr,
    output logic [AXI_ID_WD-1:0]          w_cmd_id,
    output logic [1:0]                    w_cmd_burst,
    output logic [2:0]                    w_cmd_size,
    output logic [AXI_ADDR_WD-1:0]        w_cmd_len,
    output logic                          done_valid,
    input  logic                          done_ready,
    output logic [AXI_ID_WD-1:0]          done_id,
    output logic [1:0]                    done_resp,
    output logic [$clog2(DESC_DEPTH):0]   queue_level,
    output logic                          busy
);

    localparam int PTR_WD   = $clog2(DESC_DEPTH);
    localparam int LVL_WD   = PTR_WD + 1;
    localparam int ENTRY_WD = 2 * AXI_ADDR_WD + AXI_ID_WD + 5;

    localparam logic [1:0] RESP_OK    = 2'b00;
    localparam logic [1:0] RESP_FLUSH = 2'b01;
    localparam logic [1:0] RESP_ABORT = 2'b10;
    localparam logic [1:0] RESP_ZERO  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_GUARD,
        ST_WAIT,
        ST_REPORT
`ifdef DESC_FLUSH_ON_ERR_EN
        , ST_FLUSH
`endif
    } state_t;

    state_t state_reg, state_next;

    logic [ENTRY_WD-1:0] fifo_mem [DESC_DEPTH];
    logic [PTR_WD-1:0]   wr_ptr_reg;
    logic [PTR_WD-1:0]   rd_ptr_reg;
    logic [LVL_WD-1:0]   count_reg;
    logic                push;
    logic                pop;

    logic [AXI_ADDR_WD-1:0] head_addr;
    logic [AXI_ADDR_WD-1:0] head_len;
    logic [AXI_ID_WD-1:0]   head_id;
    logic [1:0]             head_burst;
    logic [2:0]             head_size;

    logic                   cmd_valid_reg, cmd_valid_next;
    logic [AXI_ADDR_WD-1:0] cmd_addr_reg, cmd_addr_next;
    logic [AXI_ADDR_WD-1:0] cmd_len_reg, cmd_len_next;
    logic [AXI_ID_WD-1:0]   cmd_id_reg, cmd_id_next;
    logic [1:0]             cmd_burst_reg, cmd_burst_next;
    logic [2:0]             cmd_size_reg, cmd_size_next;
    logic                   err_reg, err_next;

    logic                   done_valid_reg, done_valid_next;
    logic [AXI_ID_WD-1:0]   done_id_reg, done_id_next;
    logic [1:0]             done_resp_reg, done_resp_next;

    // Ready depends only on registered state, never on desc_valid.
`ifdef DESC_FLUSH_ON_ERR_EN
    assign desc_ready = (count_reg != LVL_WD'(DESC_DEPTH)) && (state_reg != ST_FLUSH);
`else
    assign desc_ready = (count_reg != LVL_WD'(DESC_DEPTH));
`endif

    assign push = desc_valid && desc_ready;

    always_ff @(posedge M_AXI_ACLK) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {desc_addr, desc_len, desc_id, desc_burst, desc_size};
        end
    end

    assign {head_addr, head_len, head_id, head_burst, head_size} = fifo_mem[rd_ptr_reg];

    always_comb begin
        state_next      = state_reg;
        pop             = 1'b0;
        cmd_valid_next  = cmd_valid_reg;
        cmd_addr_next   = cmd_addr_reg;
        cmd_len_next    = cmd_len_reg;
        cmd_id_next     = cmd_id_reg;
        cmd_burst_next  = cmd_burst_reg;
        cmd_size_next   = cmd_size_reg;
        err_next        = err_reg;
        done_valid_next = done_valid_reg;
        done_id_next    = done_id_reg;
        done_resp_next  = done_resp_reg;

        case (state_reg)
            ST_IDLE: begin
                if (count_reg != '0) begin
                    pop            = 1'b1;
                    cmd_addr_next  = head_addr;
                    cmd_len_next   = head_len;
                    cmd_id_next    = head_id;
                    cmd_burst_next = head_burst;
                    cmd_size_next  = head_size;
                    err_next       = 1'b0;
                    // Zero-length work completes locally and never reaches the master.
                    if (head_len == '0) begin
                        done_valid_next = 1'b1;
                        done_id_next    = head_id;
                        done_resp_next  = RESP_ZERO;
                        state_next      = ST_REPORT;
                    end else begin
                        cmd_valid_next = 1'b1;
                        state_next     = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (w_cmd_ready && !w_cmd_abort) begin
                    cmd_valid_next = 1'b0;
                    state_next     = ST_GUARD;
                end
            end
            ST_GUARD: begin
                // Master's ready still reflects pre-accept idle this cycle.
                err_next   = err_reg | w_cmd_abort;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                err_next = err_reg | w_cmd_abort;
                if (w_cmd_ready && !w_cmd_abort) begin
                    done_valid_next = 1'b1;
                    done_id_next    = cmd_id_reg;
                    done_resp_next  = err_reg ? RESP_ABORT : RESP_OK;
                    state_next      = ST_REPORT;
                end
            end
            ST_REPORT: begin
                if (done_ready) begin
                    done_valid_next = 1'b0;
`ifdef DESC_FLUSH_ON_ERR_EN
                    state_next = (done_resp_reg == RESP_ABORT) ? ST_FLUSH : ST_IDLE;
`else
                    state_next = ST_IDLE;
`endif
                end
            end
`ifdef DESC_FLUSH_ON_ERR_EN
            ST_FLUSH: begin
                if (!done_valid_reg || done_ready) begin
                    if (count_reg != '0) begin
                        pop             = 1'b1;
                        done_valid_next = 1'b1;
                        done_id_next    = head_id;
                        done_resp_next  = RESP_FLUSH;
                    end else begin
                        done_valid_next = 1'b0;
                        state_next      = ST_IDLE;
                    end
                end
            end
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            state_reg      <= ST_IDLE;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            cmd_valid_reg  <= 1'b0;
            cmd_addr_reg   <= '0;
            cmd_len_reg    <= '0;
            cmd_id_reg     <= '0;
            cmd_burst_reg  <= '0;
            cmd_size_reg   <= '0;
            err_reg        <= 1'b0;
            done_valid_reg <= 1'b0;
            done_id_reg    <= '0;
            done_resp_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg      <= count_reg + LVL_WD'(push) - LVL_WD'(pop);
            cmd_valid_reg  <= cmd_valid_next;
            cmd_addr_reg   <= cmd_addr_next;
            cmd_len_reg    <= cmd_len_next;
            cmd_id_reg     <= cmd_id_next;
            cmd_burst_reg  <= cmd_burst_next;
            cmd_size_reg   <= cmd_size_next;
            err_reg        <= err_next;
            done_valid_reg <= done_valid_next;
            done_id_reg    <= done_id_next;
            done_resp_reg  <= done_resp_next;
        end
    end

    assign w_cmd_valid = cmd_valid_reg;
    assign w_cmd_addr  = cmd_addr_reg;
    assign w_cmd_len   = cmd_len_reg;
    assign w_cmd_id    = cmd_id_reg;
    assign w_cmd_burst = cmd_burst_reg;
    assign w_cmd_size  = cmd_size_reg;
    assign done_valid  = done_valid_reg;
    assign done_id     = done_id_reg;
    assign done_resp   = done_resp_reg;
    assign queue_level = count_reg;
    assign busy        = (state_reg != ST_IDLE) || (count_reg != '0);

endmodule

// File: tb/tb_dma_write_desc_queue.sv
`timescale 1ns/1ps
// Scoreboard bench for dma_write_desc_queue: expected commands/records queued at stimulus, compared on output.
module tb_dma_write_desc_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        desc_valid, desc_ready;
    logic [31:0] desc_addr, desc_len;
    logic [1:0]  desc_id, desc_burst;
    logic [2:0]  desc_size;
    logic        w_cmd_valid, w_cmd_ready, w_cmd_abort;
    logic [31:0] w_cmd_addr, w_cmd_len;
    logic [1:0]  w_cmd_id, w_cmd_burst;
    logic [2:0]  w_cmd_size;
    logic        done_valid, done_ready;
    logic [1:0]  done_id, done_resp;
    logic [2:0]  queue_level;
    logic        busy;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] len;
        logic [1:0]  id;
        logic [1:0]  burst;
        logic [2:0]  size;
    } cmd_t;

    typedef struct packed {
        logic [1:0] id;
        logic [1:0] resp;
    } done_t;

    cmd_t  exp_cmd[$], cmd_obs[$];
    done_t exp_done[$], done_obs[$];
    int    errors = 0;
    int    checks = 0;
    int    cmd_valid_cycles = 0;

    always #5 clk = ~clk;

    dma_write_desc_queue #(.AXI_ID_WD(2), .AXI_ADDR_WD(32), .DESC_DEPTH(4)) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
        .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_addr(desc_addr), .desc_len(desc_len), .desc_id(desc_id),
        .desc_burst(desc_burst), .desc_size(desc_size),
        .w_cmd_valid(w_cmd_valid), .w_cmd_ready(w_cmd_ready), .w_cmd_abort(w_cmd_abort),
        .w_cmd_addr(w_cmd_addr), .w_cmd_id(w_cmd_id), .w_cmd_burst(w_cmd_burst),
        .w_cmd_size(w_cmd_size), .w_cmd_len(w_cmd_len),
        .done_valid(done_valid), .done_ready(done_ready),
        .done_id(done_id), .done_resp(done_resp),
        .queue_level(queue_level), .busy(busy)
    );

    // Observation only: capture handshakes mid-cycle, comparisons happen in the tests.
    always @(negedge clk) begin
        if (!rst) begin
            if (w_cmd_valid) cmd_valid_cycles++;
            if (w_cmd_valid && w_cmd_ready && !w_cmd_abort)
                cmd_obs.push_back({w_cmd_addr, w_cmd_len, w_cmd_id, w_cmd_burst, w_cmd_size});
            if (done_valid && done_ready)
                done_obs.push_back({done_id, done_resp});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic cmd_t mk_cmd(input logic [31:0] a, input logic [31:0] l, input logic [1:0] id);
        return {a, l, id, 2'b01, 3'd2};
    endfunction

    task automatic set_desc(input logic [31:0] a, input logic [31:0] l, input logic [1:0] id);
        desc_addr  = a;
        desc_len   = l;
        desc_id    = id;
        desc_burst = 2'b01;
        desc_size  = 3'd2;
    endtask

    task automatic test_reset();
        rst = 1'b1; desc_valid = 1'b0; w_cmd_ready = 1'b0; w_cmd_abort = 1'b0; done_ready = 1'b0;
        set_desc(32'h0, 32'h0, 2'd0);
        repeat (3) tick();
        checks++;
        if ({desc_ready, w_cmd_valid, done_valid, busy, queue_level} !== 7'b1000_000) begin
            errors++;
            $display("FAIL reset_flags: got rdy=%b cv=%b dv=%b busy=%b lvl=%0d expected 1 0 0 0 0",
                     desc_ready, w_cmd_valid, done_valid, busy, queue_level);
        end
        checks++;
        if ({w_cmd_addr, w_cmd_len, w_cmd_id, done_id, done_resp} !== '0) begin
            errors++;
            $display("FAIL reset_fields: got addr=%h len=%h id=%0d did=%0d resp=%b expected all 0",
                     w_cmd_addr, w_cmd_len, w_cmd_id, done_id, done_resp);
        end
        rst = 1'b0;
        tick();
        $display("reset: outputs checked");
    endtask

    task automatic test_single();
        w_cmd_ready = 1'b1; done_ready = 1'b1;
        tick(); desc_valid = 1'b1; set_desc(32'h1000, 32'd64, 2'd1);
        exp_cmd.push_back(mk_cmd(32'h1000, 32'd64, 2'd1));
        exp_done.push_back({2'd1, 2'b00});
        tick(); desc_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (w_cmd_valid !== 1'b0) begin
            errors++; $display("FAIL single_early_valid: got %b expected 0", w_cmd_valid);
        end
        @(negedge clk);
        checks++;
        if (w_cmd_valid !== 1'b1 || w_cmd_addr !== 32'h1000 || w_cmd_len !== 32'd64) begin
            errors++;
            $display("FAIL single_issue: got valid=%b addr=%h len=%0d expected 1 00001000 64",
                     w_cmd_valid, w_cmd_addr, w_cmd_len);
        end
        tick(); w_cmd_ready = 1'b0;
        repeat (20) tick();
        w_cmd_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (done_valid !== 1'b0) begin
            errors++; $display("FAIL single_done_early: got %b expected 0", done_valid);
        end
        @(negedge clk);
        checks++;
        if (done_valid !== 1'b1 || done_id !== 2'd1 || done_resp !== 2'b00) begin
            errors++;
            $display("FAIL single_done_timing: got valid=%b id=%0d resp=%b expected 1 1 00",
                     done_valid, done_id, done_resp);
        end
        for (int i = 0; i < 200 && (done_obs.size() < exp_done.size() || cmd_obs.size() < exp_cmd.size()); i++)
            @(negedge clk);
        repeat (5) @(negedge clk);
        checks++;
        if (done_obs.size() != exp_done.size() || cmd_obs.size() != exp_cmd.size()) begin
            errors++;
            $display("FAIL single_count: got done=%0d cmd=%0d expected done=%0d cmd=%0d",
                     done_obs.size(), cmd_obs.size(), exp_done.size(), exp_cmd.size());
        end
        while (exp_cmd.size() > 0 && cmd_obs.size() > 0) begin
            cmd_t e = exp_cmd.pop_front();
            cmd_t o = cmd_obs.pop_front();
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL single_cmd: got %h expected %h", o, e);
            end else $display("single: cmd id=%0d addr=%h len=%0d", o.id, o.addr, o.len);
        end
        while (exp_done.size() > 0 && done_obs.size() > 0) begin
            done_t e = exp_done.pop_front();
            done_t o = done_obs.pop_front();
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL single_done: got id=%0d resp=%b expected id=%0d resp=%b", o.id, o.resp, e.id, e.resp);
            end else $display("single: done id=%0d resp=%b", o.id, o.resp);
        end
        exp_cmd.delete(); cmd_obs.delete(); exp_done.delete(); done_obs.delete();
    endtask

    task automatic test_zero_len();
        int base;
        w_cmd_ready = 1'b1; done_ready = 1'b1;
        base = cmd_valid_cycles;
        tick(); desc_valid = 1'b1; set_desc(32'h5000, 32'd0, 2'd2);
        exp_done.push_back({2'd2, 2'b11});
        tick(); desc_valid = 1'b0;
        for (int i = 0; i < 100 && done_obs.size() < exp_done.size(); i++) @(negedge clk);
        repeat (5) @(negedge clk);
        checks++;
        if (cmd_valid_cycles != base || cmd_obs.size() != 0) begin
            errors++;
            $display("FAIL zero_no_cmd: got %0d valid cycles expected 0", cmd_valid_cycles - base);
        end
        checks++;
        if (done_obs.size() != exp_done.size()) begin
            errors++; $display("FAIL zero_count: got %0d records expected %0d", done_obs.size(), exp_done.size());
        end
        while (exp_done.size() > 0 && done_obs.size() > 0) begin
            done_t e = exp_done.pop_front();
            done_t o = done_obs.pop_front();
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL zero_done: got id=%0d resp=%b expected id=%0d resp=%b", o.id, o.resp, e.id, e.resp);
            end else $display("zero_len: done id=%0d resp=%b", o.id, o.resp);
        end
        exp_cmd.delete(); cmd_obs.delete(); exp_done.delete(); done_obs.delete();
    endtask

    task automatic test_back_to_back();
        w_cmd_ready = 1'b1; done_ready = 1'b0;
        // A zero-length blocker parks the FSM in REPORT so the FIFO can fill.
        for (int i = 0; i < 5; i++) begin
            tick(); desc_valid = 1'b1;
            if (i == 0) begin
                set_desc(32'h6000, 32'd0, 2'd2);
                exp_done.push_back({2'd2, 2'b11});
            end else begin
                set_desc(32'h2000 + 32'(i - 1) * 32'h100, 32'(16 * i), 2'(i - 1));
                exp_cmd.push_back(mk_cmd(32'h2000 + 32'(i - 1) * 32'h100, 32'(16 * i), 2'(i - 1)));
                exp_done.push_back({2'(i - 1), 2'b00});
            end
            @(negedge clk);
            checks++;
            if (desc_ready !== 1'b1) begin
                errors++; $display("FAIL fill_ready[%0d]: got %b expected 1", i, desc_ready);
            end
        end
        tick(); set_desc(32'h2F00, 32'd8, 2'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (desc_ready !== 1'b0 || queue_level !== 3'd4) begin
                errors++;
                $display("FAIL fill_full[%0d]: got ready=%b level=%0d expected 0 4", i, desc_ready, queue_level);
            end
            tick();
        end
        desc_valid = 1'b0; done_ready = 1'b1;
        for (int i = 0; i < 300 && (done_obs.size() < exp_done.size() || cmd_obs.size() < exp_cmd.size()); i++)
            @(negedge clk);
        repeat (5) @(negedge clk);
        checks++;
        if (done_obs.size() != exp_done.size() || cmd_obs.size() != exp_cmd.size()) begin
            errors++;
            $display("FAIL fill_count: got done=%0d cmd=%0d expected done=%0d cmd=%0d",
                     done_obs.size(), cmd_obs.size(), exp_done.size(), exp_cmd.size());
        end
        while (exp_cmd.size() > 0 && cmd_obs.size() > 0) begin
            cmd_t e = exp_cmd.pop_front();
            cmd_t o = cmd_obs.pop_front();
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL fill_cmd: got %h expected %h", o, e);
            end else $display("back_to_back: cmd id=%0d addr=%h len=%0d", o.id, o.addr, o.len);
        end
        while (exp_done.size() > 0 && done_obs.size() > 0) begin
            done_t e = exp_done.pop_front();
            done_t o = done_obs.pop_front();
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL fill_done: got id=%0d resp=%b expected id=%0d resp=%b", o.id, o.resp, e.id, e.resp);
            end else $display("back_to_back: done id=%0d resp=%b", o.id, o.resp);
        end
        exp_cmd.delete(); cmd_obs.delete(); exp_done.delete(); done_obs.delete();
    endtask

    task automatic test_abort();
        w_cmd_ready = 1'b0; done_ready = 1'b1; w_cmd_abort = 1'b0;
        tick(); desc_valid = 1'b1; set_desc(32'h4000, 32'd32, 2'd0);
        exp_cmd.push_back(mk_cmd(32'h4000, 32'd32, 2'd0));
        exp_done.push_back({2'd0, 2'b10});
        tick(); set_desc(32'h4100, 32'd48, 2'd3);
`ifdef DESC_FLUSH_ON_ERR_EN
        exp_done.push_back({2'd3, 2'b01});
`else
        exp_cmd.push_back(mk_cmd(32'h4100, 32'd48, 2'd3));
        exp_done.push_back({2'd3, 2'b00});
`endif
        tick(); desc_valid = 1'b0; w_cmd_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (w_cmd_valid !== 1'b1 || w_cmd_id !== 2'd0) begin
            errors++; $display("FAIL abort_issue: got valid=%b id=%0d expected 1 0", w_cmd_valid, w_cmd_id);
        end
        tick(); w_cmd_ready = 1'b0;
        tick(); w_cmd_abort = 1'b1;
        tick(); tick();
        tick(); w_cmd_abort = 1'b0; w_cmd_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (done_valid !== 1'b0) begin
            errors++; $display("FAIL abort_done_early: got %b expected 0", done_valid);
        end
        @(negedge clk);
        checks++;
        if (done_valid !== 1'b1 || done_resp !== 2'b10) begin
            errors++; $display("FAIL abort_done: got valid=%b resp=%b expected 1 10", done_valid, done_resp);
        end
        for (int i = 0; i < 200 && (done_obs.size() < exp_done.size() || cmd_obs.size() < exp_cmd.size()); i++)
            @(negedge clk);
        repeat (5) @(negedge clk);
        checks++;
        if (done_obs.size() != exp_done.size() || cmd_obs.size() != exp_cmd.size()) begin
            errors++;
            $display("FAIL abort_count: got done=%0d cmd=%0d expected done=%0d cmd=%0d",
                     done_obs.size(), cmd_obs.size(), exp_done.size(), exp_cmd.size());
        end
        while (exp_cmd.size() > 0 && cmd_obs.size() > 0) begin
            cmd_t e = exp_cmd.pop_front();
            cmd_t o = cmd_obs.pop_front();
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL abort_cmd: got %h expected %h", o, e);
            end else $display("abort: cmd id=%0d addr=%h len=%0d", o.id, o.addr, o.len);
        end
        while (exp_done.size() > 0 && done_obs.size() > 0) begin
            done_t e = exp_done.pop_front();
            done_t o = done_obs.pop_front();
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL abort_done_rec: got id=%0d resp=%b expected id=%0d resp=%b", o.id, o.resp, e.id, e.resp);
            end else $display("abort: done id=%0d resp=%b", o.id, o.resp);
        end
        exp_cmd.delete(); cmd_obs.delete(); exp_done.delete(); done_obs.delete();
    endtask

`ifdef DESC_FLUSH_ON_ERR_EN
    task automatic test_flush();
        int  base;
        bit  found;
        w_cmd_ready = 1'b0; done_ready = 1'b1; w_cmd_abort = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(); desc_valid = 1'b1; set_desc(32'h7000 + 32'(i) * 32'h40, 32'(8 * (i + 1)), 2'(i));
        end
        exp_cmd.push_back(mk_cmd(32'h7000, 32'd8, 2'd0));
        exp_done.push_back({2'd0, 2'b10});
        for (int i = 1; i < 4; i++) exp_done.push_back({2'(i), 2'b01});
        tick(); desc_valid = 1'b0; w_cmd_ready = 1'b1;
        tick(); w_cmd_ready = 1'b0;
        base = cmd_valid_cycles;
        tick(); w_cmd_abort = 1'b1;
        tick(); tick();
        tick(); w_cmd_abort = 1'b0; w_cmd_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (done_valid && done_resp == 2'b01) found = 1'b1;
        end
        checks++;
        if (!found || desc_ready !== 1'b0) begin
            errors++; $display("FAIL flush_ready: got found=%b ready=%b expected 1 0", found, desc_ready);
        end
        tick(); done_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (done_valid !== 1'b1 || done_id !== 2'd2 || done_resp !== 2'b01) begin
                errors++;
                $display("FAIL flush_stall[%0d]: got valid=%b id=%0d resp=%b expected 1 2 01", i, done_valid, done_id, done_resp);
            end
            tick();
        end
        done_ready = 1'b1;
        for (int i = 0; i < 200 && (done_obs.size() < exp_done.size() || cmd_obs.size() < exp_cmd.size()); i++)
            @(negedge clk);
        repeat (5) @(negedge clk);
        checks++;
        if (cmd_valid_cycles != base || queue_level !== 3'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_end: got extra_valid=%0d level=%0d busy=%b expected 0 0 0",
                     cmd_valid_cycles - base, queue_level, busy);
        end
        checks++;
        if (done_obs.size() != exp_done.size() || cmd_obs.size() != exp_cmd.size()) begin
            errors++;
            $display("FAIL flush_count: got done=%0d cmd=%0d expected done=%0d cmd=%0d",
                     done_obs.size(), cmd_obs.size(), exp_done.size(), exp_cmd.size());
        end
        while (exp_cmd.size() > 0 && cmd_obs.size() > 0) begin
            cmd_t e = exp_cmd.pop_front();
            cmd_t o = cmd_obs.pop_front();
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL flush_cmd: got %h expected %h", o, e);
            end else $display("flush: cmd id=%0d addr=%h len=%0d", o.id, o.addr, o.len);
        end
        while (exp_done.size() > 0 && done_obs.size() > 0) begin
            done_t e = exp_done.pop_front();
            done_t o = done_obs.pop_front();
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL flush_done: got id=%0d resp=%b expected id=%0d resp=%b", o.id, o.resp, e.id, e.resp);
            end else $display("flush: done id=%0d resp=%b", o.id, o.resp);
        end
        exp_cmd.delete(); cmd_obs.delete(); exp_done.delete(); done_obs.delete();
    endtask
`endif

    task automatic test_stall_reset();
        bit found;
        w_cmd_ready = 1'b1; done_ready = 1'b0; w_cmd_abort = 1'b0;
        tick(); desc_valid = 1'b1; set_desc(32'h3000, 32'd0, 2'd2);
        exp_done.push_back({2'd2, 2'b11});
        tick(); desc_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (done_valid) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL stall_wait: got no done_valid expected 1 within 20 cycles");
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 0) begin
                desc_valid = 1'b1; set_desc(32'h3100, 32'd16, 2'd1);
                exp_cmd.push_back(mk_cmd(32'h3100, 32'd16, 2'd1));
            end else if (i == 1) begin
                set_desc(32'h3200, 32'd32, 2'd3);
            end else begin
                desc_valid = 1'b0;
            end
            @(negedge clk);
            checks++;
            if (done_valid !== 1'b1 || done_id !== 2'd2 || done_resp !== 2'b11) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got valid=%b id=%0d resp=%b expected 1 2 11", i, done_valid, done_id, done_resp);
            end
        end
        tick(); done_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (w_cmd_valid && w_cmd_ready) found = 1'b1;
        end
        tick(); w_cmd_ready = 1'b0;
        tick(); tick();
        @(negedge clk);
        checks++;
        if (!found || busy !== 1'b1 || queue_level !== 3'd1) begin
            errors++;
            $display("FAIL stall_pre_reset: got fired=%b busy=%b level=%0d expected 1 1 1", found, busy, queue_level);
        end
        tick(); rst = 1'b1;
        tick(); tick(); rst = 1'b0; w_cmd_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({desc_ready, w_cmd_valid, done_valid, busy, queue_level} !== 7'b1000_000 ||
            {w_cmd_addr, w_cmd_len, done_id, done_resp} !== '0) begin
            errors++;
            $display("FAIL stall_post_reset: got rdy=%b cv=%b dv=%b busy=%b lvl=%0d addr=%h expected 1 0 0 0 0 0",
                     desc_ready, w_cmd_valid, done_valid, busy, queue_level, w_cmd_addr);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (done_obs.size() != exp_done.size() || cmd_obs.size() != exp_cmd.size()) begin
            errors++;
            $display("FAIL stall_count: got done=%0d cmd=%0d expected done=%0d cmd=%0d",
                     done_obs.size(), cmd_obs.size(), exp_done.size(), exp_cmd.size());
        end
        while (exp_cmd.size() > 0 && cmd_obs.size() > 0) begin
            cmd_t e = exp_cmd.pop_front();
            cmd_t o = cmd_obs.pop_front();
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL stall_cmd: got %h expected %h", o, e);
            end else $display("stall_reset: cmd id=%0d addr=%h len=%0d", o.id, o.addr, o.len);
        end
        while (exp_done.size() > 0 && done_obs.size() > 0) begin
            done_t e = exp_done.pop_front();
            done_t o = done_obs.pop_front();
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL stall_done: got id=%0d resp=%b expected id=%0d resp=%b", o.id, o.resp, e.id, e.resp);
            end else $display("stall_reset: done id=%0d resp=%b", o.id, o.resp);
        end
        exp_cmd.delete(); cmd_obs.delete(); exp_done.delete(); done_obs.delete();
    endtask

    initial begin
        test_reset();
        test_single();
        test_zero_len();
        test_back_to_back();
        test_abort();
`ifdef DESC_FLUSH_ON_ERR_EN
        test_flush();
`endif
        test_stall_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
